// File: rtl/robs_divider_pkg.sv
// Shared types and helpers for the Robertson multiplier/divider datapaths.
// Helpers work on a 64-bit word; callers size-cast to their own width.
package robs_pkg;

    localparam int ROBS_WIDTH = 8;
    localparam int ROBS_MAXW  = 64;

    typedef enum logic [2:0] {IDLE, LOAD, DIV, SIGN, DONE} div_state_t;

    typedef logic [ROBS_MAXW-1:0] robs_word_t;

    function automatic robs_word_t neg_w(input robs_word_t v);
        return ~v + robs_word_t'(1);
    endfunction

    function automatic robs_word_t abs_w(input robs_word_t v);
        return v[ROBS_MAXW-1] ? neg_w(v) : v;
    endfunction

endpackage

// File: rtl/robs_divider_counter.sv
// Loadable iteration down-counter; zero flags the decrement that lands on 0.
// Load has priority over decrement; the count saturates at 0.
module div_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         ena,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (ena && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Asserted during the last enabled cycle so the FSM can leave DIV on time.
    assign zero = ena && (count == W'(1));

endmodule

// File: rtl/robs_divider.sv
// Signed restoring divider, one quotient bit per clock; done WIDTH+3 cycles after start
// (2 cycles on a zero divisor with ROBS_DIV_ZERO_CHECK_EN). No backpressure: start is ignored while busy.
module robs_divider
    import robs_pkg::*;
#(
    parameter int WIDTH = ROBS_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH:0]   p_r;
    logic             sq;
    logic             sr;
    logic             cnt_zero;
    logic [WIDTH+1:0] p_shift;
    logic [WIDTH+1:0] trial;

    // The top bit of p_shift is always 0, so trial's MSB is the borrow of P - |divisor|.
    assign p_shift = {p_r, q_r[WIDTH-1]};
    assign trial   = p_shift - {2'b00, dmag};

    div_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (state == LOAD),
        .ena   (state == DIV),
        .value (CW'(WIDTH)),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dvd_r     <= '0;
            dvs_r     <= '0;
            q_r       <= '0;
            dmag      <= '0;
            p_r       <= '0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_r     <= dividend;
                        dvs_r     <= divisor;
                        sq        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sr        <= dividend[WIDTH-1];
                        quotient  <= '0;
                        remainder <= '0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // The most-negative operand's magnitude 2^(WIDTH-1) still fits unsigned.
                    q_r  <= WIDTH'(abs_w(robs_word_t'(signed'(dvd_r))));
                    dmag <= WIDTH'(abs_w(robs_word_t'(signed'(dvs_r))));
                    p_r  <= '0;
`ifdef ROBS_DIV_ZERO_CHECK_EN
                    if (dvs_r == '0) begin
                        quotient  <= '1;
                        remainder <= dvd_r;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= DIV;
                    end
`else
                    state <= DIV;
`endif
                end
                DIV: begin
                    if (!trial[WIDTH+1]) begin
                        p_r <= trial[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        p_r <= p_shift[WIDTH:0];
                        q_r <= {q_r[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_zero) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    quotient  <= sq ? WIDTH'(neg_w(robs_word_t'(q_r))) : q_r;
                    remainder <= sr ? WIDTH'(neg_w(robs_word_t'(p_r[WIDTH-1:0])))
                                    : p_r[WIDTH-1:0];
                    ovf       <= (dvd_r == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_r == '1);
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROBS_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbz <= 1'b0;
        end else if (state == IDLE && start) begin
            dbz <= 1'b0;
        end else if (state == LOAD && dvs_r == '0) begin
            dbz <= 1'b1;
        end
    end
`else
    assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_robs_divider.sv
// Directed plus random bench for robs_divider with a queue scoreboard of expected results.
module tb_robs_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    robs_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        int   ia;
        int   ib;
        ia    = int'(a);
        ib    = int'(b);
        e.ovf = 1'b0;
        e.dbz = 1'b0;
        e.lat = W + 3;
        if (ib == 0) begin
            e.r = a;
`ifdef ROBS_DIV_ZERO_CHECK_EN
            e.q   = '1;
            e.dbz = 1'b1;
            e.lat = 2;
`else
            e.q = (ia < 0) ? 8'h01 : 8'hFF;
`endif
        end else begin
            e.q   = W'(ia / ib);
            e.r   = W'(ia % ib);
            e.ovf = (ia == -128) && (ib == -1);
        end
        return e;
    endfunction

    // poke > 0 pulses start with unrelated operands in that cycle of the running op.
    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input int poke);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == poke) begin
                start    = 1'b1;
                dividend = 8'h81;
                divisor  = 8'h02;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        e = sb.pop_front();
        check("done_seen", 32'(done), 32'(1));
        check("done_cycle", 32'(cyc), 32'(e.lat));
        check("busy_through_op", 32'(busy_ok && busy === 1'b1), 32'(1));
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("dbz", 32'(dbz), 32'(e.dbz));
        check("ovf", 32'(ovf), 32'(e.ovf));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'(0));
        check("busy_clear", 32'(busy), 32'(0));
        check("quotient_hold", 32'(quotient), 32'(e.q));
    endtask

    initial begin
        int  seen_done;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_dbz", 32'(dbz), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op(8'sd100, 8'sd7, 0);
        run_op(-8'sd100, 8'sd7, 0);
        run_op(8'sd100, -8'sd7, 0);
        run_op(-8'sd100, -8'sd7, 0);
        run_op(8'sh80, -8'sd1, 0);
        run_op(8'sd55, 8'sd0, 0);
        run_op(-8'sd55, 8'sd0, 0);
        run_op(8'sh80, 8'sd1, 0);
        run_op(8'sd127, 8'sh80, 0);
        run_op(8'sd100, 8'sd7, 5);

        // Abort a fresh op in cycle 6 with reset.
        @(negedge clk);
        dividend = 8'sd90;
        divisor  = 8'sd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_quotient", 32'(quotient), 32'(0));
        check("abort_remainder", 32'(remainder), 32'(0));
        check("abort_dbz", 32'(dbz), 32'(0));
        check("abort_ovf", 32'(ovf), 32'(0));
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'(0));

        run_op(-8'sd77, 8'sd5, 0);
        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom), W'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/robs_divider.md
# robs_divider

Signed integer divider: the inverse of the team's Robertson's multiplier datapath. It accepts a two's-complement dividend and divisor, runs one restoring-division iteration per clock, and returns a truncated quotient and remainder. It sits beside the multiplier on the same arithmetic bus and uses the same start/done style of control.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits (two's complement).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  signed dividend; captured on the accepting edge.
- `divisor`  in  WIDTH  signed divisor; captured on the accepting edge.
- `quotient`  out  WIDTH  signed quotient, truncated toward zero.
- `remainder`  out  WIDTH  signed remainder; its sign follows the dividend.
- `busy`  out  1  high from the accepting edge until `done`.
- `done`  out  1  single-cycle completion pulse.
- `dbz`  out  1  divide-by-zero flag; valid while `done` is high.
- `ovf`  out  1  set for the single overflow case, most-negative / −1.

## Operation
- FSM states: IDLE, LOAD, DIV, SIGN, DONE.
- **IDLE:** when `start`=1, capture the operands, latch `sq = dividend[MSB]^divisor[MSB]` and `sr = dividend[MSB]`, and go to LOAD.
- **LOAD:** form the unsigned magnitudes `|dividend|` and `|divisor|` in WIDTH bits. The most-negative value has magnitude 2^(WIDTH−1), which fits.
  - Clear the partial remainder P (WIDTH+1 bits).
  - Load the down-counter with WIDTH.
  - Go to DIV.
- **DIV:** repeat for WIDTH cycles:
  - Shift {P,Q} left by 1.
  - Trial `T = P − |divisor|`. If T ≥ 0, set P = T and Q[0] = 1; otherwise keep P and set Q[0] = 0.
  - Decrement the counter. When the counter reaches 0, go to SIGN.
- **SIGN:**
  - quotient = sq ? −Q : Q.
  - remainder = sr ? −P[WIDTH−1:0] : P[WIDTH−1:0].
  - `ovf` = (dividend is most-negative) & (divisor = −1). The quotient then wraps to most-negative; remainder = 0.
  - Go to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- `quotient`, `remainder`, `dbz` and `ovf` hold their values until the next accepted `start`. They are updated only in SIGN and cleared on the acceptance edge.
- `start` while `busy` is ignored and has no side effects.
- `dbz` behaviour depends on the configuration macro (see Configuration).

## Timing
- Reset values: state = IDLE; `quotient`, `remainder`, `busy`, `done`, `dbz`, `ovf` = 0; counter = 0.
- Reset mid-operation aborts immediately with no `done` pulse. The operation must be restarted after `reset` deasserts.
- Let edge 0 be the edge that samples `start`.
  - LOAD is cycle 1.
  - DIV is cycles 2 … WIDTH+1.
  - SIGN is cycle WIDTH+2.
  - `done`=1 during cycle WIDTH+3; for WIDTH=8, `done` is high in cycle 11.
- `busy`=1 from cycle 1 through cycle WIDTH+3 inclusive. `busy` and `done` are both high in the DONE cycle.
- Results are stable from cycle WIDTH+3 onward.
- A new `start` may be accepted on the first IDLE cycle after DONE (back-to-back throughput = WIDTH+4 cycles).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `ROBS_DIV_ZERO_CHECK_EN`.
- Defined: in LOAD, a zero `divisor` skips DIV and SIGN and goes straight to DONE, so `done` occurs in cycle 2. Outputs: quotient = all ones, remainder = dividend, `dbz`=1, `ovf`=0.
- Undefined: `dbz` is tied to 0, and a zero divisor runs the full WIDTH iterations. Results are the algorithm's natural outputs:
  - Q = all ones, so the quotient is −1 if the dividend is non-negative and +1 if the dividend is negative (because of the sign fixup).
  - remainder = dividend.

## Structure
- Shared package `robs_pkg` holds:
  - the state enum `div_state_t` (IDLE, LOAD, DIV, SIGN, DONE);
  - the localparam `ROBS_WIDTH` = 8;
  - helper functions `abs_w` and `neg_w`.
- One sub-module, `div_counter`: a loadable down-counter with async reset, `load`, `ena` and a `zero` output. It counts iterations and drives the DIV→SIGN transition.
- The FSM and the shift/subtract datapath live in the top module.

## Test plan
- 100 / 7 → quotient 14, remainder 2, `done` in cycle 11, `busy` high in cycles 1–11.
- −100 / 7 → −14, −2.
- 100 / −7 → −14, 2.
- −100 / −7 → 14, −2.
- −128 / −1 → quotient −128 (0x80), remainder 0, `ovf`=1.
- 55 / 0 with the macro defined → `done` in cycle 2, quotient 0xFF, remainder 55, `dbz`=1.
- 55 / 0 with the macro undefined → `done` in cycle 11, quotient −1, remainder 55, `dbz`=0.
- `start` pulsed in cycle 5 of a running op → ignored, first result unchanged. Then assert `reset` in cycle 6 of a fresh op → all outputs 0 and no `done`. A new op after reset completes correctly.
